// File: rtl/deck_pkg.sv
// Shared constants, state encoding and card-ID decode helpers for deck_dealer.
package deck_pkg;

    localparam int DECK_SIZE = 52;
    localparam int NUM_RANKS = 13;

    // Galois feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_PICK  = 3'd2;
    localparam logic [2:0] S_SWAP  = 3'd3;
    localparam logic [2:0] S_READY = 3'd4;

    function automatic logic [1:0] id_suit(input logic [5:0] id);
        if (id >= 6'd39)
            return 2'd3;
        else if (id >= 6'd26)
            return 2'd2;
        else if (id >= 6'd13)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    function automatic logic [3:0] id_rank(input logic [5:0] id);
        logic [5:0] r;
        r = id;
        if (id >= 6'd39)
            r = id - 6'd39;
        else if (id >= 6'd26)
            r = id - 6'd26;
        else if (id >= 6'd13)
            r = id - 6'd13;
        return r[3:0] + 4'd1;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, loaded with the seed during reset.
module lfsr16
    import deck_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = {1'b0, state_q[15:1]};
        if (state_q[0])
            state_d = state_d ^ LFSR_TAPS;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_q <= seed;
        else
            state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/deck_dealer.sv
// Card deck shuffler (Fisher-Yates with rejection sampling) and dealer.
module deck_dealer
    import deck_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_shuffle,
    input  logic       start_card,
    output logic       shuffling,
    output logic       shuffle_ready,
    output logic       card_ready,
    output logic [3:0] card_rank,
    output logic [1:0] card_suit,
    output logic [5:0] cards_left,
    output logic       deck_empty
);

    logic [15:0] lfsr;

    lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .seed  (SEED),
        .state (lfsr)
    );

    logic [2:0] state_q, state_d;
    logic       shuf_q, shuf_d;
    logic       card_q, card_d;
    logic [5:0] idx_q, idx_d;
    logic [5:0] j_q, j_d;
    logic [5:0] ptr_q, ptr_d;
    logic [5:0] left_q, left_d;
    logic       shuffling_q, shuffling_d;
    logic       sready_q, sready_d;
    logic       cready_q, cready_d;
    logic [3:0] rank_q, rank_d;
    logic [1:0] suit_q, suit_d;
    logic [5:0] deck_q [DECK_SIZE];
    logic [5:0] deck_d [DECK_SIZE];

    logic shuf_edge;
    logic card_edge;

    assign shuf_edge = start_shuffle & ~shuf_q;
    assign card_edge = start_card & ~card_q;

    always_comb begin
        state_d     = state_q;
        shuf_d      = start_shuffle;
        card_d      = start_card;
        idx_d       = idx_q;
        j_d         = j_q;
        ptr_d       = ptr_q;
        left_d      = left_q;
        shuffling_d = shuffling_q;
        sready_d    = sready_q;
        cready_d    = 1'b0;
        rank_d      = rank_q;
        suit_d      = suit_q;
        deck_d      = deck_q;

        case (state_q)
            S_IDLE, S_READY: begin
                // A shuffle request takes priority over a simultaneous deal
                if (shuf_edge) begin
                    state_d     = S_INIT;
                    shuffling_d = 1'b1;
                    sready_d    = 1'b0;
                    left_d      = 6'd0;
                end else if (state_q == S_READY && card_edge
                             && left_q != 6'd0) begin
                    cready_d = 1'b1;
                    rank_d   = id_rank(deck_q[ptr_q]);
                    suit_d   = id_suit(deck_q[ptr_q]);
                    ptr_d    = ptr_q + 6'd1;
                    left_d   = left_q - 6'd1;
                end
            end
            S_INIT: begin
                for (int k = 0; k < DECK_SIZE; k++)
                    deck_d[k] = 6'(k);
                idx_d       = 6'(DECK_SIZE - 1);
                shuffling_d = 1'b1;
                sready_d    = 1'b0;
                left_d      = 6'd0;
                state_d     = S_PICK;
            end
            S_PICK: begin
                if (lfsr[5:0] <= idx_q) begin
                    j_d     = lfsr[5:0];
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                deck_d[idx_q] = deck_q[j_q];
                deck_d[j_q]   = deck_q[idx_q];
                if (idx_q > 6'd1) begin
                    idx_d   = idx_q - 6'd1;
                    state_d = S_PICK;
                end else begin
                    ptr_d       = 6'd0;
                    left_d      = 6'(DECK_SIZE);
                    shuffling_d = 1'b0;
                    sready_d    = 1'b1;
                    state_d     = S_READY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            shuf_q      <= 1'b0;
            card_q      <= 1'b0;
            idx_q       <= 6'd0;
            j_q         <= 6'd0;
            ptr_q       <= 6'd0;
            left_q      <= 6'd0;
            shuffling_q <= 1'b0;
            sready_q    <= 1'b0;
            cready_q    <= 1'b0;
            rank_q      <= 4'd0;
            suit_q      <= 2'd0;
            for (int k = 0; k < DECK_SIZE; k++)
                deck_q[k] <= 6'(k);
        end else begin
            state_q     <= state_d;
            shuf_q      <= shuf_d;
            card_q      <= card_d;
            idx_q       <= idx_d;
            j_q         <= j_d;
            ptr_q       <= ptr_d;
            left_q      <= left_d;
            shuffling_q <= shuffling_d;
            sready_q    <= sready_d;
            cready_q    <= cready_d;
            rank_q      <= rank_d;
            suit_q      <= suit_d;
            deck_q      <= deck_d;
        end
    end

    assign shuffling     = shuffling_q;
    assign shuffle_ready = sready_q;
    assign card_ready    = cready_q;
    assign card_rank     = rank_q;
    assign card_suit     = suit_q;
    assign cards_left    = left_q;
    assign deck_empty    = (left_q == 6'd0);

endmodule

// File: doc/deck_dealer.md
DECK_DEALER -- requirements
Module: deck_dealer

Interface
REQ-001 SHALL have parameter SEED, default 16'hACE1, giving the LFSR reset value (nonzero).
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port start_shuffle  input  1  shuffle request from game controller; rising edge acts.
REQ-005 SHALL have port start_card  input  1  deal request from game controller; rising edge acts.
REQ-006 SHALL have port shuffling  output  1  high while a shuffle is in progress.
REQ-007 SHALL have port shuffle_ready  output  1  high when a shuffled deck is available.
REQ-008 SHALL have port card_ready  output  1  one-cycle strobe: card_rank/card_suit valid.
REQ-009 SHALL have port card_rank  output  4  dealt card rank, 1 (ace) to 13 (king).
REQ-010 SHALL have port card_suit  output  2  dealt card suit, 0 to 3.
REQ-011 SHALL have port cards_left  output  6  undealt cards remaining, 0 to 52.
REQ-012 SHALL have port deck_empty  output  1  high when cards_left == 0.

Function
REQ-013 SHALL hold a 52-entry deck register array of 6-bit card IDs (0..51); rank = ID mod 13 + 1; suit = ID / 13.
REQ-014 SHALL detect edges on start_shuffle/start_card with one registered copy each; a held level acts only once.
REQ-015 SHALL run a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, advancing every cycle out of reset.
REQ-016 SHALL implement states S_IDLE, S_INIT, S_PICK, S_SWAP, S_READY.
REQ-017 S_IDLE/S_READY + start_shuffle edge -> S_INIT; in S_INIT, in one cycle: deck[k]=k for all k, index i=51, shuffle_ready=0, shuffling=1, cards_left=0.
REQ-018 S_INIT -> S_PICK; in S_PICK, r = LFSR[5:0]: if r <= i, latch j=r and go to S_SWAP; else stay (rejection, retry next cycle).
REQ-019 S_SWAP SHALL swap deck[i] and deck[j] in one cycle, then: i > 1 -> i-1, back to S_PICK; i == 1 -> S_READY with pointer=0, cards_left=52, shuffling=0, shuffle_ready=1.
REQ-020 start_shuffle edges during S_INIT/S_PICK/S_SWAP SHALL be ignored; start_card edges outside S_READY SHALL be ignored.
REQ-021 In S_READY, start_card edge with cards_left > 0 SHALL drive card_ready=1 on the next cycle for exactly one cycle, card_rank/card_suit from deck[pointer], pointer+1, cards_left-1.
REQ-022 card_rank/card_suit SHALL hold their value until the next deal or reset.
REQ-023 start_card edge with cards_left == 0 SHALL produce no card_ready; deck_empty remains 1; state remains S_READY.
REQ-024 Simultaneous start_shuffle and start_card edges in S_READY: shuffle SHALL win, no card dealt.
REQ-025 shuffle_ready SHALL stay 1 in S_READY even when empty; it clears only on a new shuffle.

Reset
REQ-026 On reset low, the block SHALL enter S_IDLE with outputs shuffling=0, shuffle_ready=0, card_ready=0, card_rank=0, card_suit=0, cards_left=0, deck_empty=1, LFSR=SEED, and edge registers=0.
REQ-027 Reset asserted mid-shuffle or mid-deal SHALL abort immediately; after release, a new start_shuffle edge is required.

Structure
REQ-028 Package deck_pkg SHALL hold DECK_SIZE=52, NUM_RANKS=13, the LFSR tap constant, and the state encoding.
REQ-029 The LFSR SHALL be a sub-module lfsr16 (clock, reset, seed in, 16-bit state out).

Verification
REQ-030 Reset, then start_shuffle pulse -> shuffling=1 within 2 cycles; later shuffling=0, shuffle_ready=1, cards_left=52; no card_ready during shuffle.
REQ-031 After shuffle, 52 start_card pulses -> 52 card_ready strobes, each 1 cycle after its edge; the 52 (rank,suit) pairs are all distinct; cards_left reaches 0 and deck_empty=1.
REQ-032 53rd start_card pulse -> no card_ready; deck_empty=1; cards_left=0.
REQ-033 start_card held high 10 cycles in S_READY -> exactly one card_ready; cards_left 52->51.
REQ-034 Simultaneous start_shuffle and start_card edges in S_READY -> no card_ready; shuffling=1; cards_left=0.
REQ-035 Reset low during S_PICK -> all outputs at reset values that cycle; start_card after release -> no card_ready.
